// File: rtl/ram_arbiter.sv
// Arbitrates the single 8-bit external RAM between video fetch, CPU and an optional boot loader.
// Build-time option: define RAM_LOADER_EN to add the write-only loader port (lreq/la/ld/lack).
module ram_arbiter #(
    parameter int unsigned ACC = 2,
    parameter int unsigned AW  = 21
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vreq,
    input  logic [AW-1:0] va,
    output logic [7:0]    vq,
    output logic          vvalid,
    output logic          vovr,
    input  logic          creq,
    input  logic          cwe,
    input  logic [AW-1:0] ca,
    input  logic [7:0]    cd,
    output logic [7:0]    cq,
    output logic          cack,
`ifdef RAM_LOADER_EN
    input  logic          lreq,
    input  logic [AW-1:0] la,
    input  logic [7:0]    ld,
    output logic          lack,
`endif
    output logic          ramWe,
    output logic          ramOe,
    output logic [7:0]    ramDo,
    input  logic [7:0]    ramDi,
    output logic [AW-1:0] ramA
);

    typedef enum logic [1:0] {StIdle, StAccRd, StAccWr, StTurn} state_e;
    typedef enum logic [1:0] {OwnVideo, OwnCpu, OwnLoader} owner_e;

    localparam logic [2:0] LastCnt = 3'(ACC - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          vpend_q, vpend_d;
    logic [AW-1:0] vaddr_q, vaddr_d;
    logic          vovr_q, vovr_d;
    logic [7:0]    vq_q, vq_d;
    logic [7:0]    cq_q, cq_d;
    logic          vvalid_q, vvalid_d;
    logic          cack_q, cack_d;
    logic          lack_q, lack_d;
    logic          ram_we_q, ram_we_d;
    logic          ram_oe_q, ram_oe_d;
    logic [7:0]    ram_do_q, ram_do_d;
    logic [AW-1:0] ram_a_q, ram_a_d;

    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;

`ifdef RAM_LOADER_EN
    assign ld_req  = lreq;
    assign ld_addr = la;
    assign ld_data = ld;
    assign lack    = lack_q;
`else
    assign ld_req  = 1'b0;
    assign ld_addr = '0;
    assign ld_data = '0;
    logic unused_lack;
    assign unused_lack = lack_q;
`endif

    // Write strobe window inside an ACC_WR access; short accesses strobe on the first cycle.
    function automatic logic we_strobe(input logic [2:0] idx);
        if (ACC == 2) return idx == 3'd0;
        return (idx != 3'd0) && (idx <= 3'(ACC - 2));
    endfunction

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        vpend_d  = vpend_q;
        vaddr_d  = vaddr_q;
        vovr_d   = vovr_q;
        vq_d     = vq_q;
        cq_d     = cq_q;
        vvalid_d = 1'b0;
        cack_d   = 1'b0;
        lack_d   = 1'b0;
        ram_do_d = ram_do_q;
        ram_a_d  = ram_a_q;

        if (vreq) begin
            if (vpend_q) begin
                vovr_d = 1'b1;
            end
            vpend_d = 1'b1;
            vaddr_d = va;
        end

        case (state_q)
            StIdle: begin
                cnt_d = 3'd0;
                if (vreq || vpend_q) begin
                    state_d = StAccRd;
                    owner_d = OwnVideo;
                    ram_a_d = vreq ? va : vaddr_q;
                    vpend_d = 1'b0;
                end else if (ld_req) begin
                    state_d  = StAccWr;
                    owner_d  = OwnLoader;
                    ram_a_d  = ld_addr;
                    ram_do_d = ld_data;
                end else if (creq && !cack_q) begin
                    // creq still high in its own cack cycle belongs to the finished access
                    owner_d = OwnCpu;
                    ram_a_d = ca;
                    if (cwe) begin
                        state_d  = StAccWr;
                        ram_do_d = cd;
                    end else begin
                        state_d = StAccRd;
                    end
                end
            end
            StAccRd: begin
                if (cnt_q == LastCnt) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                    if (owner_q == OwnVideo) begin
                        vq_d     = ramDi;
                        vvalid_d = 1'b1;
                    end else begin
                        cq_d   = ramDi;
                        cack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StAccWr: begin
                if (cnt_q == LastCnt) begin
                    state_d = StTurn;
                    cnt_d   = 3'd0;
                    if (owner_q == OwnLoader) begin
                        lack_d = 1'b1;
                    end else begin
                        cack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Pad controls are registered from the next state so they change cleanly on the edge.
        ram_oe_d = (state_d == StAccWr);
        ram_we_d = !((state_d == StAccWr) && we_strobe(cnt_d));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            owner_q  <= OwnVideo;
            cnt_q    <= 3'd0;
            vpend_q  <= 1'b0;
            vaddr_q  <= '0;
            vovr_q   <= 1'b0;
            vq_q     <= 8'h00;
            cq_q     <= 8'h00;
            vvalid_q <= 1'b0;
            cack_q   <= 1'b0;
            lack_q   <= 1'b0;
            ram_we_q <= 1'b1;
            ram_oe_q <= 1'b0;
            ram_do_q <= 8'h00;
            ram_a_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            vpend_q  <= vpend_d;
            vaddr_q  <= vaddr_d;
            vovr_q   <= vovr_d;
            vq_q     <= vq_d;
            cq_q     <= cq_d;
            vvalid_q <= vvalid_d;
            cack_q   <= cack_d;
            lack_q   <= lack_d;
            ram_we_q <= ram_we_d;
            ram_oe_q <= ram_oe_d;
            ram_do_q <= ram_do_d;
            ram_a_q  <= ram_a_d;
        end
    end

    assign vq     = vq_q;
    assign vvalid = vvalid_q;
    assign vovr   = vovr_q;
    assign cq     = cq_q;
    assign cack   = cack_q;
    assign ramWe  = ram_we_q;
    assign ramOe  = ram_oe_q;
    assign ramDo  = ram_do_q;
    assign ramA   = ram_a_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations plus random traffic
// checked every cycle against a grant-schedule reference model.
module tb_ram_arbiter;

    localparam int ACC = 2;
    localparam int AW  = 21;

    logic          clock = 1'b0;
    logic          reset;
    logic          vreq;
    logic [AW-1:0] va;
    logic [7:0]    vq;
    logic          vvalid, vovr;
    logic          creq, cwe;
    logic [AW-1:0] ca;
    logic [7:0]    cd, cq;
    logic          cack;
    logic          lreq;
    logic [AW-1:0] la;
    logic [7:0]    ld;
    logic          lack;
    logic          ramWe, ramOe;
    logic [7:0]    ramDo, ramDi;
    logic [AW-1:0] ramA;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ACC(ACC), .AW(AW)) dut (
        .clock  (clock),
        .reset  (reset),
        .vreq   (vreq),
        .va     (va),
        .vq     (vq),
        .vvalid (vvalid),
        .vovr   (vovr),
        .creq   (creq),
        .cwe    (cwe),
        .ca     (ca),
        .cd     (cd),
        .cq     (cq),
        .cack   (cack),
`ifdef RAM_LOADER_EN
        .lreq   (lreq),
        .la     (la),
        .ld     (ld),
        .lack   (lack),
`endif
        .ramWe  (ramWe),
        .ramOe  (ramOe),
        .ramDo  (ramDo),
        .ramDi  (ramDi),
        .ramA   (ramA)
    );

`ifndef RAM_LOADER_EN
    assign lack = 1'b0;
`endif

    always #5 clock = ~clock;

    // External RAM pad model, aliased on the low address byte.
    logic [7:0] ram_mem [256];
    logic [7:0] ref_mem [256];
    assign ramDi = ram_mem[ramA[7:0]];
    always @(posedge clock) begin
        if (ramWe === 1'b0 && ramOe === 1'b1) ram_mem[ramA[7:0]] <= ramDo;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wr_strobe(input int k);
        if (k == 0) return ACC == 2;
        return k <= ACC - 2;
    endfunction

    // Reference model: one record for the latest granted access, timing derived from its start.
    int            n_cyc = 0;
    bit            a_valid = 0, a_wr = 0;
    int            a_start = 0, a_owner = 0;
    logic [AW-1:0] a_addr = '0;
    logic [7:0]    a_data = '0;
    int            free_at = 0, last_cack = -10;
    bit            m_vpend = 0, m_vovr = 0;
    logic [AW-1:0] m_vaddr = '0, m_ramA = '0;
    logic [7:0]    m_ramDo = '0, m_vq = '0, m_cq = '0;

    task automatic grant(input int n, input int owner, input bit wr,
                         input logic [AW-1:0] addr, input logic [7:0] data);
        a_valid = 1;
        a_start = n;
        a_owner = owner;
        a_wr    = wr;
        a_addr  = addr;
        m_ramA  = addr;
        if (wr) begin
            a_data  = data;
            m_ramDo = data;
            ref_mem[addr[7:0]] = data;
            free_at = n + ACC + 2;
        end else begin
            a_data  = ref_mem[addr[7:0]];
            free_at = n + ACC + 1;
        end
    endtask

    always @(negedge clock) begin
        bit in_acc, done, vgrant;
        in_acc = a_valid && n_cyc > a_start && n_cyc <= a_start + ACC;
        done   = a_valid && n_cyc == a_start + ACC + 1;
        if (done && !a_wr) begin
            if (a_owner == 0) m_vq = a_data;
            else m_cq = a_data;
        end
        chk("ramA", 32'(ramA), 32'(m_ramA));
        chk("ramOe", 32'(ramOe), 32'(in_acc && a_wr));
        chk("ramWe", 32'(ramWe), 32'(!(in_acc && a_wr && wr_strobe(n_cyc - a_start - 1))));
        chk("ramDo", 32'(ramDo), 32'(m_ramDo));
        chk("vvalid", 32'(vvalid), 32'(done && !a_wr && a_owner == 0));
        chk("vq", 32'(vq), 32'(m_vq));
        chk("vovr", 32'(vovr), 32'(m_vovr));
        chk("cack", 32'(cack), 32'(done && a_owner == 1));
        chk("cq", 32'(cq), 32'(m_cq));
`ifdef RAM_LOADER_EN
        chk("lack", 32'(lack), 32'(done && a_owner == 2));
`endif
        if (reset) begin
            a_valid = 0;
            free_at = n_cyc + 1;
            m_vpend = 0;
            m_vovr  = 0;
            m_ramA  = '0;
            m_ramDo = '0;
            m_vq    = '0;
            m_cq    = '0;
            last_cack = -10;
        end else begin
            if (done && a_owner == 1) last_cack = n_cyc;
            if (vreq && m_vpend) m_vovr = 1;
            vgrant = 0;
            if (n_cyc >= free_at) begin
                if (vreq || m_vpend) begin
                    grant(n_cyc, 0, 0, vreq ? va : m_vaddr, 8'h00);
                    m_vpend = 0;
                    vgrant  = 1;
                end else if (lreq) begin
                    grant(n_cyc, 2, 1, la, ld);
                end else if (creq && last_cack != n_cyc) begin
                    grant(n_cyc, 1, cwe, ca, cd);
                end
            end
            if (vreq && !vgrant) begin
                m_vpend = 1;
                m_vaddr = va;
            end
        end
        n_cyc++;
    end

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    bit busy = 0, chain = 0;

    task automatic new_req();
        creq = 1;
        cwe  = 1'($urandom);
        ca   = AW'($urandom);
        cd   = 8'($urandom);
        busy = 1;
    endtask

    initial begin
        int cnt, vcyc, lcnt;
        logic [7:0] vqv;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        ram_mem[8'h34] = 8'h5A;
        ref_mem[8'h34] = 8'h5A;
        reset = 1; vreq = 0; va = '0; creq = 0; cwe = 0; ca = '0; cd = '0;
        lreq = 0; la = '0; ld = '0;
        repeat (3) next_cycle();
        reset = 0;
        chk("rst_ramWe", 32'(ramWe), 32'd1);
        chk("rst_ramOe", 32'(ramOe), 32'd0);
        chk("rst_ramA", 32'(ramA), 32'd0);
        chk("rst_ramDo", 32'(ramDo), 32'd0);
        chk("rst_vvalid_vovr_cack", {29'd0, vvalid, vovr, cack}, 32'd0);
        chk("rst_vq_cq", {16'd0, vq, cq}, 32'd0);
        next_cycle();

        // Video read
        vreq = 1; va = 21'h01234;
        next_cycle(); vreq = 0;
        chk("vid_ramA_c1", 32'(ramA), 32'h01234);
        next_cycle();
        chk("vid_ramA_c2", 32'(ramA), 32'h01234);
        next_cycle();
        chk("vid_vvalid_c3", 32'(vvalid), 32'd1);
        chk("vid_vq_c3", 32'(vq), 32'h5A);
        chk("vid_vovr", 32'(vovr), 32'd0);
        repeat (2) next_cycle();

        // CPU write then read-back
        creq = 1; cwe = 1; ca = 21'h00100; cd = 8'hC3;
        next_cycle();
        chk("wr_ramOe_c1", 32'(ramOe), 32'd1);
        chk("wr_ramWe_c1", 32'(ramWe), 32'd0);
        chk("wr_ramDo_c1", 32'(ramDo), 32'hC3);
        next_cycle();
        chk("wr_ramOe_c2", 32'(ramOe), 32'd1);
        chk("wr_ramWe_c2", 32'(ramWe), 32'd1);
        next_cycle();
        chk("wr_cack_c3", 32'(cack), 32'd1);
        chk("wr_ramOe_c3", 32'(ramOe), 32'd0);
        next_cycle(); creq = 0;
        next_cycle(); creq = 1; cwe = 0;
        repeat (3) next_cycle();
        chk("rd_cack", 32'(cack), 32'd1);
        chk("rd_cq", 32'(cq), 32'hC3);
        next_cycle(); creq = 0;
        repeat (2) next_cycle();

        // Collision: video wins, CPU read follows
        vreq = 1; va = 21'h00050; creq = 1; cwe = 0; ca = 21'h00034;
        next_cycle(); vreq = 0;
        chk("col_ramA_c1", 32'(ramA), 32'h00050);
        repeat (2) next_cycle();
        chk("col_vvalid_c3", 32'(vvalid), 32'd1);
        chk("col_vq_c3", 32'(vq), 32'hF5);
        chk("col_cack_c3", 32'(cack), 32'd0);
        next_cycle();
        chk("col_ramA_c4", 32'(ramA), 32'h00034);
        next_cycle();
        chk("col_cack_c5", 32'(cack), 32'd0);
        next_cycle();
        chk("col_cack_c6", 32'(cack), 32'd1);
        chk("col_cq_c6", 32'(cq), 32'h5A);
        next_cycle(); creq = 0;
        chk("model_cq", 32'(m_cq), 32'h5A);
        repeat (2) next_cycle();

        // Overrun while a CPU write is in flight
        creq = 1; cwe = 1; ca = 21'h00077; cd = 8'h11;
        next_cycle(); vreq = 1; va = 21'h00061;
        next_cycle(); vreq = 1; va = 21'h00062;
        next_cycle(); vreq = 0;
        chk("ovr_cack_c3", 32'(cack), 32'd1);
        chk("ovr_vovr_c3", 32'(vovr), 32'd1);
        cnt = 0; vcyc = -1; vqv = 8'h00;
        for (int c = 4; c < 14; c++) begin
            next_cycle();
            if (c == 4) creq = 0;
            if (c == 5) chk("ovr_ramA_c5", 32'(ramA), 32'h00062);
            if (vvalid) begin
                cnt++;
                vcyc = c;
                vqv  = vq;
            end
        end
        chk("ovr_vvalid_count", 32'(cnt), 32'd1);
        chk("ovr_vvalid_cycle", 32'(vcyc), 32'd7);
        chk("ovr_vq", 32'(vqv), 32'hC7);
        chk("model_vovr", 32'(m_vovr), 32'd1);

        // Reset during a write
        creq = 1; cwe = 1; ca = 21'h00010; cd = 8'h99;
        next_cycle(); reset = 1; creq = 0;
        chk("rstw_ramWe_c1", 32'(ramWe), 32'd0);
        next_cycle(); reset = 0;
        chk("rstw_ramWe", 32'(ramWe), 32'd1);
        chk("rstw_ramOe", 32'(ramOe), 32'd0);
        chk("rstw_vovr", 32'(vovr), 32'd0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (cack) cnt++;
            next_cycle();
        end
        chk("rstw_no_cack", 32'(cnt), 32'd0);

`ifdef RAM_LOADER_EN
        // Loader keeps the CPU out while lreq is held
        lreq = 1; la = 21'h00200; ld = 8'h3C; creq = 1; cwe = 0; ca = 21'h00003;
        lcnt = 0; cnt = -1;
        for (int c = 0; c < 40 && cnt < 0; c++) begin
            next_cycle();
            if (lack) begin
                lcnt++;
                la = la + 1'b1;
                if (lcnt == 3) lreq = 0;
            end
            if (cack) begin
                cnt  = lcnt;
                creq = 0;
            end
        end
        chk("ldr_lacks_before_cack", 32'(cnt), 32'd3);
        lreq = 0; creq = 0;
        repeat (3) next_cycle();
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            reset = ($urandom_range(0, 299) == 0);
            vreq  = ($urandom_range(0, 4) == 0);
            va    = AW'($urandom);
            if (busy && cack) begin
                busy  = 0;
                chain = 1;
            end else if (chain) begin
                chain = 0;
                if ($urandom_range(0, 3) == 0) new_req();
                else creq = 0;
            end else if (busy && $urandom_range(0, 19) == 0) begin
                busy = 0;
                creq = 0;
            end else if (!busy && $urandom_range(0, 2) == 0) begin
                new_req();
            end
        end
        reset = 0; vreq = 0; creq = 0;
        repeat (12) next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
